// File: rtl/register_32_if.sv
// rtl/register_32_if.sv - load/data bundle between a datapath register and its driver
interface register_32_if #(
    parameter int WIDTH = 32
);
    logic             enable;
    logic [WIDTH-1:0] DataIn;
    logic [WIDTH-1:0] DataOut;

    modport master (
        output enable,
        output DataIn,
        input  DataOut
    );

    modport slave (
        input  enable,
        input  DataIn,
        output DataOut
    );
endinterface

// File: rtl/register_32.sv
// rtl/register_32.sv - parallel-load datapath register with synchronous clear
module register_32 #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic         clock,
    input  logic         clear,
    register_32_if.slave bus
);
    // Initialiser only shapes simulation power-up; silicon starts undefined.
    logic [WIDTH-1:0] q = RESET_VALUE;

    always_ff @(posedge clock) begin
        if (clear) begin
            q <= RESET_VALUE;
        end else if (bus.enable) begin
            q <= bus.DataIn;
        end
    end

    assign bus.DataOut = q;
endmodule

// File: tb/tb_register_32.sv
// tb/tb_register_32.sv - directed self-checking bench for register_32
module tb_register_32;
    localparam logic [31:0] RV2 = 32'hCAFE_0001;

    logic        clock = 1'b0;
    logic        clear;
    logic        en;
    logic [31:0] din;

    int errors = 0;
    int checks = 0;

    register_32_if #(.WIDTH(32)) bus1 ();
    register_32_if #(.WIDTH(32)) bus2 ();

    assign bus1.enable = en;
    assign bus1.DataIn = din;
    assign bus2.enable = en;
    assign bus2.DataIn = din;

    register_32 #(.WIDTH(32)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus1)
    );

    register_32 #(.WIDTH(32), .RESET_VALUE(RV2)) dut2 (
        .clock (clock),
        .clear (clear),
        .bus   (bus2)
    );

    always #50 clock = ~clock;

    typedef struct {
        logic        clr;
        logic        ena;
        logic [31:0] data;
        logic [31:0] expect_q;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [31:0] model2;

        vecs[0] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[1] = '{1'b0, 1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
        vecs[2] = '{1'b0, 1'b1, 32'h5A5A_5A5A, 32'h5A5A_5A5A};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0000, 32'h5A5A_5A5A};
        vecs[4] = '{1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0000};
        vecs[5] = '{1'b1, 1'b0, 32'h1234_5678, 32'h0000_0000};
        vecs[6] = '{1'b0, 1'b1, 32'h1357_9BDF, 32'h1357_9BDF};
        vecs[7] = '{1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000};
        vecs[8] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[9] = '{1'b0, 1'b1, 32'h0000_0080, 32'h0000_0080};

        clear = 1'b0;
        en    = 1'b1;
        din   = 32'h0000_0000;

        #10;
        check("powerup", bus1.DataOut, 32'h0000_0000);
        check("powerup_rv", bus2.DataOut, RV2);

        #41;  // 51 ns
        check("first_edge", bus1.DataOut, 32'h0000_0000);

        #24 din = 32'h0000_0001;  // 75 ns
        #1  check("no_comb_path", bus1.DataOut, 32'h0000_0000);

        #75;  // 151 ns
        check("load_1", bus1.DataOut, 32'h0000_0001);

        #74 clear = 1'b1;  // 225 ns
        #1  check("clear_not_async", bus1.DataOut, 32'h0000_0001);

        #25;  // 251 ns
        check("clear_over_enable", bus1.DataOut, 32'h0000_0000);
        check("clear_rv", bus2.DataOut, RV2);

        #100;  // 351 ns
        check("clear_held", bus1.DataOut, 32'h0000_0000);

        #29 clear = 1'b0;  // 380 ns
        #71;  // 451 ns
        check("no_dead_cycle", bus1.DataOut, 32'h0000_0001);
        check("no_dead_cycle_rv", bus2.DataOut, 32'h0000_0001);

        #84 en = 1'b0;  // 535 ns
        #160 din = 32'h0000_0012;  // 695 ns
        #1  check("hold_between_edges", bus1.DataOut, 32'h0000_0001);
        #55;  // 751 ns
        check("hold_750", bus1.DataOut, 32'h0000_0001);
        #100;  // 851 ns
        check("hold_850", bus1.DataOut, 32'h0000_0001);

        model2 = 32'h0000_0001;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            clear = vecs[i].clr;
            en    = vecs[i].ena;
            din   = vecs[i].data;
            @(posedge clock);
            #1;
            if (vecs[i].clr)      model2 = RV2;
            else if (vecs[i].ena) model2 = vecs[i].data;
            check($sformatf("vec%0d", i), bus1.DataOut, vecs[i].expect_q);
            check($sformatf("vec%0d_rv", i), bus2.DataOut, model2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/register_32.md
# register_32

General-purpose, edge-triggered, parallel-load data register for the CPU datapath: the building block for the register file and the special registers (PC, IR, MAR, MDR, HI/LO, Y, Z). It captures a data word on the rising clock edge when enabled and holds it otherwise. A synchronous clear forces the stored word to zero.

## Interface
- WIDTH, 32: data width in bits; all data ports use this width.
- RESET_VALUE, 0 (WIDTH bits): value loaded by `clear`; defaults to all-zeros.
- clock  input  1  single system clock; all state changes on its rising edge.
- clear  input  1  reset, synchronous and active-high; loads RESET_VALUE on the next rising edge.
- enable  input  1  load enable, active-high.
- DataIn  input  WIDTH  word to be captured.
- DataOut  output  WIDTH  stored word, driven directly from the state flops (no combinational path from inputs).

## Operation
- The block stores one WIDTH-bit word in a flop bank (`q`). DataOut = q at all times.
- At each rising edge of `clock`, exactly one of the following applies, in this priority order:
  - `clear`=1: q <= RESET_VALUE. This holds regardless of `enable` and DataIn.
  - `clear`=0, `enable`=1: q <= DataIn.
  - `clear`=0, `enable`=0: q holds its value.
- No arithmetic, no width conversion. DataIn is captured bit-for-bit.
- Power-up value before the first clear or load is undefined in silicon. Simulation models initialise q to RESET_VALUE so benches that never pulse `clear` see 0.

## Timing
- Load latency: 1 edge. DataIn sampled at edge N is visible on DataOut right after edge N, and stays stable until the next qualifying edge.
- Clear latency: 1 edge. There is no asynchronous path, so asserting `clear` between edges has no effect until the next rising edge.
- DataIn and `enable` changes between edges have no effect on DataOut.
- Clear held for several cycles: DataOut stays RESET_VALUE for every edge at which `clear` is sampled high.
- First edge after `clear` deasserts, with `enable`=1: loads the current DataIn. There is no dead cycle.
- Simultaneous `clear`=1 and `enable`=1 with a nonzero DataIn: clear wins and DataOut becomes RESET_VALUE.
- Reset mid-operation: a clear edge discards the held value. No other state exists.
- Inputs must meet setup/hold around the rising edge. Setup/hold violations are out of scope.

## Test plan
- Clock period 100 ns, first rising edge at 50 ns, `clear`=0, `enable`=1, DataIn=0x00000000 -> DataOut=0x00000000 after the 50 ns edge.
- DataIn=0x00000001 at 75 ns, `enable`=1 -> DataOut=0x00000001 after the 150 ns edge and unchanged through the 250 ns edge's setup window. DataOut must not change at 75 ns.
- `clear`=1 at 225 ns while `enable`=1 and DataIn=0x00000001 -> DataOut=0x00000000 after the 250 ns edge and held through the 350 ns edge. This checks that clear has priority over enable.
- `clear`=0 at 380 ns, `enable`=1, DataIn=0x00000001 -> DataOut=0x00000001 after the 450 ns edge, with no dead cycle.
- `enable`=0 at 535 ns, then DataIn=0x00000012 at 695 ns -> DataOut stays 0x00000001 through the 750 ns and 850 ns edges. The hold must not glitch.
- Re-enable with DataIn=0xFFFFFFFF, then 0xA5A5A5A5 on consecutive edges -> DataOut follows each value with one-edge latency. Every bit is covered at both polarities.
